// File: rtl/tune_pkg.sv
// tune_pkg: shared state encoding and ROM word field helpers for the tune sequencer.
package tune_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, FIN} state_t;
  localparam int DUR_W = 7;
  function automatic int word_w(int mw);
    return mw + DUR_W + 1;
  endfunction
  function automatic int end_bit(int mw);
    return mw + DUR_W;
  endfunction
  function automatic int dur_msb(int mw);
    return mw + DUR_W - 1;
  endfunction
  function automatic int dur_lsb(int mw);
    return mw;
  endfunction
endpackage

// File: rtl/tune_sequencer_if.sv
// tune_sequencer_if: control, song ROM and PWM signals between host side and sequencer.
interface tune_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int MAX_WAVE = 24
);
  logic start;
  logic stop;
  logic loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [tune_pkg::word_w(MAX_WAVE)-1:0] rom_data;
  logic [MAX_WAVE-1:0] period;
  logic [MAX_WAVE-1:0] compare;
  logic pwm_rst;
  logic busy;
  logic done;
  modport master (
    output start, stop, loop_en, rom_data,
    input rom_addr, period, compare, pwm_rst, busy, done
  );
  modport slave (
    input start, stop, loop_en, rom_data,
    output rom_addr, period, compare, pwm_rst, busy, done
  );
endinterface

// File: rtl/beat_timer.sv
// beat_timer: free-running cycle counter that ticks once every BEAT_CYCLES enabled cycles.
module beat_timer #(
  parameter int BEAT_CYCLES = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(BEAT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/tune_sequencer.sv
// tune_sequencer: plays a ROM song by driving PWM period/compare/reset with beat timing and note gaps.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int MAX_WAVE = 24,
  parameter int ADDR_W = 6,
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES = 500000
) (
  input logic clk,
  input logic rst,
  tune_sequencer_if.slave bus
);
  localparam int END_BIT = end_bit(MAX_WAVE);
  localparam int DUR_MSB = dur_msb(MAX_WAVE);
  localparam int DUR_LSB = dur_lsb(MAX_WAVE);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state;
  logic [DUR_W-1:0] dur, beats, rd_dur;
  logic [GW-1:0] gap_cnt;
  logic [MAX_WAVE-1:0] rd_per;
  logic rd_end, tick, gap_end, fin;
  assign rd_end = bus.rom_data[END_BIT];
  assign rd_dur = bus.rom_data[DUR_MSB:DUR_LSB];
  assign rd_per = bus.rom_data[MAX_WAVE-1:0];
  // fin covers both song-end paths: an END word, or running off the last address
  always_comb begin
    gap_end = state == GAP && gap_cnt == GW'(GAP_CYCLES - 1);
    fin = (state == LOAD && rd_end && !(bus.loop_en && bus.rom_addr != '0))
       || (gap_end && &bus.rom_addr && !bus.loop_en);
  end
  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en(state == PLAY),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst || (bus.stop && state != IDLE)) begin
      state <= IDLE;
      bus.rom_addr <= '0;
      bus.period <= '0;
      bus.compare <= '0;
      bus.pwm_rst <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      dur <= '0;
      beats <= '0;
      gap_cnt <= '0;
    end else if (fin) begin
      state <= FIN;
      bus.done <= 1'b1;
      bus.busy <= 1'b0;
      bus.pwm_rst <= 1'b1;
      bus.period <= '0;
      bus.compare <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.stop) begin
          state <= FETCH;
          bus.rom_addr <= '0;
          bus.busy <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: if (rd_end) begin
          state <= FETCH;
          bus.rom_addr <= '0;
        end else begin
          state <= PLAY;
          bus.period <= rd_per;
          bus.compare <= rd_per >> 1;
          bus.pwm_rst <= rd_per == '0;
          dur <= rd_dur == '0 ? DUR_W'(1) : rd_dur;
          beats <= '0;
        end
        PLAY: if (tick) begin
          if (beats + 1'b1 == dur) begin
            state <= GAP;
            bus.pwm_rst <= 1'b1;
            gap_cnt <= '0;
          end else beats <= beats + 1'b1;
        end
        // the address wraps naturally, which is exactly the looping restart
        GAP: if (gap_end) begin
          state <= FETCH;
          bus.rom_addr <= bus.rom_addr + 1'b1;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tune_sequencer.sv
// tb_tune_sequencer: directed vectors, corner sequences and random songs against a timeline model.
module tb_tune_sequencer;
  localparam int AW = 3, MW = 24, BC = 4, GC = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tune_sequencer_if #(.ADDR_W(AW), .MAX_WAVE(MW)) bus ();
  tune_sequencer #(.MAX_WAVE(MW), .ADDR_W(AW), .BEAT_CYCLES(BC), .GAP_CYCLES(GC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [31:0] rom [8];
  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int checks = 0, passes = 0, cyc = 0;
  logic [53:0] expq [$];
  typedef struct {
    logic [7:0][31:0] song;
    bit lp;
    int done_cyc;
    int probe;
    logic [23:0] pp, pc;
    bit pr;
  } vec_t;
  vec_t tv [5];
  function automatic logic [31:0] word(bit e, int d, int p);
    return {e, 7'(d), 24'(p)};
  endfunction
  function automatic logic [53:0] pk(int a, logic [23:0] p, logic [23:0] c, bit r, bit b, bit d);
    return {3'(a), p, c, r, b, d};
  endfunction
  function automatic logic [53:0] outs();
    return {bus.rom_addr, bus.period, bus.compare, bus.pwm_rst, bus.busy, bus.done};
  endfunction
  function automatic vec_t mk(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, bit lp, int dc,
                              int pb, int pp, int pc, bit pr);
    vec_t v;
    v.song = '0;
    v.song[0] = w0;
    v.song[1] = w1;
    v.song[2] = w2;
    v.lp = lp;
    v.done_cyc = dc;
    v.probe = pb;
    v.pp = 24'(pp);
    v.pc = 24'(pc);
    v.pr = pr;
    return v;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
  endtask
  task automatic load3(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    for (int k = 0; k < 8; k++) rom[k] = '0;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask
  task automatic wait_done(input int limit, output int at);
    at = -1;
    while (at < 0 && cyc < limit) begin
      if (bus.done) at = cyc;
      else step();
    end
  endtask
  // timeline model: each ROM word expands into fetch, load, play and gap cycles
  function automatic void build(bit lp, int maxlen);
    int a, d;
    logic [23:0] per, cmp;
    logic [31:0] wd;
    bit fin;
    a = 0; per = '0; cmp = '0; fin = 0;
    expq.delete();
    while (!fin && expq.size() < maxlen) begin
      wd = rom[a];
      expq.push_back(pk(a, per, cmp, 1, 1, 0));
      expq.push_back(pk(a, per, cmp, 1, 1, 0));
      if (wd[31]) begin
        if (lp && a != 0) a = 0;
        else fin = 1;
      end else begin
        d = wd[30:24] == 0 ? 1 : int'(wd[30:24]);
        per = wd[23:0];
        cmp = per / 2;
        repeat (d * BC) expq.push_back(pk(a, per, cmp, per == 0, 1, 0));
        repeat (GC) expq.push_back(pk(a, per, cmp, 1, 1, 0));
        if (a == 7) begin
          if (lp) a = 0;
          else fin = 1;
        end else a++;
      end
    end
    if (fin) begin
      expq.push_back(pk(a, 0, 0, 1, 0, 1));
      expq.push_back(pk(a, 0, 0, 1, 0, 0));
    end
  endfunction
  task automatic run_model(string name, bit lp, int maxlen);
    build(lp, maxlen);
    bus.loop_en = lp;
    pulse_start();
    for (int i = 0; i < expq.size(); i++) begin
      chk(name, outs(), expq[i]);
      if (i < expq.size() - 1) step();
    end
    if (expq[expq.size()-1][1]) begin
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk({name, " stop"}, outs(), pk(0, 0, 0, 1, 0, 0));
    end
    step();
  endtask
  initial begin
    int at, nd;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    for (int k = 0; k < 8; k++) rom[k] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outs", outs(), pk(0, 0, 0, 1, 0, 0));
    rst = 1'b0;
    step();
    chk("idle after reset", outs(), pk(0, 0, 0, 1, 0, 0));
    tv[0] = mk(word(0, 2, 100), word(1, 0, 0), 0, 0, 15, 3, 100, 50, 0);
    tv[1] = mk(word(0, 1, 0), word(0, 0, 101), word(1, 0, 0), 0, 19, 11, 101, 50, 0);
    tv[2] = mk(word(1, 0, 0), 0, 0, 1, 3, 2, 0, 0, 1);
    tv[3] = mk(0, 0, 0, 0, 65, 59, 7, 3, 0);
    for (int k = 0; k < 8; k++) tv[3].song[k] = word(0, 1, 7);
    tv[4] = mk(word(0, 3, 24'hffffff), word(1, 0, 0), 0, 0, 19, 14, 24'hffffff, 24'h7fffff, 0);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 8; k++) rom[k] = tv[i].song[k];
      bus.loop_en = tv[i].lp;
      pulse_start();
      at = -1;
      while (at < 0 && cyc < 200) begin
        if (cyc == tv[i].probe)
          chk($sformatf("vec%0d probe", i), {bus.period, bus.compare, bus.pwm_rst},
              {tv[i].pp, tv[i].pc, tv[i].pr});
        if (bus.done) at = cyc;
        else step();
      end
      chk($sformatf("vec%0d done cycle", i), at, tv[i].done_cyc);
      chk($sformatf("vec%0d busy at done", i), bus.busy, 0);
      step();
      chk($sformatf("vec%0d done width", i), bus.done, 0);
    end
    bus.loop_en = 1'b0;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("start+stop busy", {bus.busy, bus.done}, 0);
    step();
    chk("start+stop stays idle", {bus.busy, bus.pwm_rst}, 2'b01);
    load3(word(0, 2, 100), word(1, 0, 0), 0);
    pulse_start();
    at = -1;
    while (at < 0 && cyc < 100) begin
      bus.start = cyc == 5 || cyc == 9;
      if (bus.done) at = cyc;
      else step();
    end
    bus.start = 1'b0;
    chk("start while busy ignored", at, 15);
    step();
    pulse_start();
    while (cyc < 6) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop mid play", outs(), pk(0, 0, 0, 1, 0, 0));
    nd = 0;
    repeat (20) begin
      step();
      nd += int'(bus.done);
    end
    chk("stop no done", nd, 0);
    run_model("replay after stop", 0, 300);
    pulse_start();
    while (cyc < 11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst mid gap", outs(), pk(0, 0, 0, 1, 0, 0));
    step();
    load3(word(0, 1, 10), word(0, 1, 20), word(1, 0, 0));
    bus.loop_en = 1'b1;
    pulse_start();
    nd = 0;
    while (cyc < 19) begin
      nd += int'(bus.done);
      step();
    end
    chk("loop back to addr 0", {bus.busy, bus.rom_addr}, {1'b1, 3'd0});
    chk("loop no done", nd, 0);
    step();
    bus.loop_en = 1'b0;
    wait_done(100, at);
    chk("loop exit done", at, 37);
    step();
    for (int k = 0; k < 8; k++) rom[k] = word(0, 1, 7);
    bus.loop_en = 1'b1;
    pulse_start();
    while (cyc < 65) step();
    chk("full song wraps", {bus.busy, bus.done, bus.rom_addr}, {2'b10, 3'd0});
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++)
        rom[k] = $urandom_range(0, 7) == 0 ? {1'b1, 7'($urandom), 24'($urandom)}
               : word(0, $urandom_range(0, 3), $urandom_range(0, 3) == 0 ? 0 : int'($urandom));
      run_model($sformatf("random song %0d", r), 1'($urandom_range(0, 1)), 150);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
Note sequencer that plays a song stored in an external synchronous ROM by driving the period/compare inputs and the reset of the existing PWM tone generator.
Each ROM word holds an end flag, a duration in beats, and a tone period; period 0 is a rest.
Between notes the block inserts a fixed silent gap so repeated notes articulate.
It sits between the song ROM and the PWM block and exposes a start/stop/loop control interface to top-level buttons or a host.

Parameters:
MAX_WAVE, 24, width of the period/compare values; must match the PWM block.
ADDR_W, 6, ROM address width; the song holds at most 2^ADDR_W words.
BEAT_CYCLES, 6250000, clk cycles per beat (125 ms at 50 MHz).
GAP_CYCLES, 500000, silent clk cycles inserted after every note or rest.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin playback at address 0; ignored while busy
stop  in  1  abort playback immediately
loop_en  in  1  on end of song, restart at address 0 instead of finishing
rom_addr  out  ADDR_W  song ROM address
rom_data  in  WORD_W  ROM word, valid one cycle after rom_addr (registered ROM)
period  out  MAX_WAVE  to PWM period
compare  out  MAX_WAVE  to PWM compare
pwm_rst  out  1  to PWM rst; high = silent, counter cleared
busy  out  1  high from the cycle after start until playback ends
done  out  1  one-cycle pulse on normal song completion

Behaviour:
- ROM word layout, WORD_W = 8+MAX_WAVE: [WORD_W-1] END; [WORD_W-2:MAX_WAVE] duration in beats, 7 bits, 0 treated as 1; [MAX_WAVE-1:0] period.
- Reset values: rom_addr 0, period 0, compare 0, pwm_rst 1, busy 0, done 0. State is IDLE; all counters are 0.
- States are IDLE, FETCH, LOAD, PLAY, GAP, and FIN.
- IDLE: start=1 → FETCH at the next cycle, with rom_addr=0 and busy=1.
- FETCH: present rom_addr for one cycle, then go to LOAD.
- LOAD: sample rom_data.
  - END=1 with loop_en=1 and rom_addr≠0 → rom_addr=0, go to FETCH.
  - END=1 otherwise (including END at address 0, i.e. an empty song) → FIN.
  - END=0 → latch period, set compare = period>>1 (truncating), go to PLAY.
- PLAY: lasts exactly dur×BEAT_CYCLES cycles.
  - pwm_rst=0 if period≠0.
  - pwm_rst=1 and compare=0 if period=0 (rest).
  - period and compare are stable for the whole interval.
- GAP: lasts exactly GAP_CYCLES cycles.
  - pwm_rst=1; period and compare hold their values.
  - At the end: if rom_addr = 2^ADDR_W−1, treat as END, with the same loop_en rule.
  - Otherwise rom_addr+1 → FETCH.
- FIN: done=1 for one cycle, busy=0, pwm_rst=1, period and compare cleared → IDLE.
- Note-to-note latency: the last GAP cycle, then FETCH and LOAD, so PLAY of the next note starts 2 cycles after GAP ends.
- stop=1 in any non-IDLE state:
  - next cycle is IDLE with reset values (rom_addr, period, compare, pwm_rst, busy).
  - no done pulse.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.
- rst mid-playback: identical to the reset values at the next edge.
- Beat timing:
  - Cycle counter of width $clog2(BEAT_CYCLES) wraps at BEAT_CYCLES−1 and produces a beat tick.
  - A 7-bit beat counter ends PLAY on the dur-th tick.
  - Both counters clear on entry to PLAY.
  - The GAP counter is separate, or the cycle counter reused and reloaded.
- All outputs are registered.

Decomposition:
- Package tune_pkg: state enum; WORD_W; field positions END_BIT, DUR_MSB, DUR_LSB; DUR_W=7.
- Sub-module beat_timer: cycle counter with clear/enable and a tick output, parameterised by BEAT_CYCLES. It is instantiated for PLAY timing; the GAP count stays in the top level.

Test Plan:
Bench parameters for all scenarios: BEAT_CYCLES=4, GAP_CYCLES=2, ADDR_W=3, MAX_WAVE=24.
1. Single note, ROM {dur2/per100, END}, start pulse at cycle 0:
   - rom_addr=0 at cycle 1.
   - period=100, compare=50, pwm_rst=0 for cycles 3–10.
   - pwm_rst=1 for cycles 11–12.
   - rom_addr=1, then END, then done pulse; busy low after it.
2. Rest and odd period, ROM {dur1/per0, dur0/per101, END}:
   - pwm_rst=1 and compare=0 for 4 cycles.
   - Then gap, then period=101, compare=50, pwm_rst=0 for 4 cycles (dur0 counts as 1 beat).
3. Loop, loop_en=1 with a 2-note song:
   - After END, rom_addr returns to 0 with no done pulse.
   - Drop loop_en during the second pass → done after the next END.
4. Stop mid-PLAY:
   - Next cycle IDLE, pwm_rst=1, period=0, busy=0, no done.
   - A new start replays from address 0.
5. Full 8-word song with no END:
   - loop_en=0: done after address 7's gap.
   - loop_en=1: rom_addr wraps to 0.
6. Corner cases:
   - start with stop in the same cycle → stays IDLE.
   - start during PLAY → ignored.
   - rst mid-GAP → all outputs at reset values next cycle.
   - END at address 0 with loop_en=1 → done pulse, no hang.
